// File: rtl/txn_engine.sv
// txn_engine: coin-ledger transfer engine, multi-cycle checks then atomic commit.
// Optional macro TXN_ENGINE_STATS_EN adds ok_count/err_count outputs.
module txn_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int ID_W        = 1,
  parameter int BAL_W       = 11,
  parameter int AMT_W       = 8,
  parameter int KEY_W       = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [ID_W-1:0]              src_id,
  input  logic [ID_W-1:0]              dst_id,
  input  logic [AMT_W-1:0]             amount,
  input  logic [KEY_W-1:0]             input_key,
  input  logic [NUM_PLAYERS*KEY_W-1:0] key_table,
  input  logic                         init_en,
  input  logic [ID_W-1:0]              init_id,
  input  logic [BAL_W-1:0]             init_value,
  input  logic [ID_W-1:0]              rd_id,
  output logic [BAL_W-1:0]             rd_balance,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   status
`ifdef TXN_ENGINE_STATS_EN
  ,
  output logic [15:0]                  ok_count,
  output logic [15:0]                  err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_AMT,
    S_CHK_KEY,
    S_COMMIT,
    S_RESP
  } state_t;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_ERR_ID  = 3'd1;
  localparam logic [2:0] ST_ERR_AMT = 3'd2;
  localparam logic [2:0] ST_ERR_KEY = 3'd3;
  localparam logic [2:0] ST_ERR_OVF = 3'd4;

  localparam logic [ID_W:0] NP = (ID_W+1)'(NUM_PLAYERS);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   src_q, src_d;
  logic [ID_W-1:0]   dst_q, dst_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [2:0]        res_q, res_d;
  logic              done_q, done_d;
  logic [2:0]        status_q, status_d;
  logic [BAL_W-1:0]  bal_q [NUM_PLAYERS];
  logic [BAL_W-1:0]  bal_d [NUM_PLAYERS];

  logic [BAL_W-1:0]  src_bal;
  logic [BAL_W-1:0]  dst_bal;
  logic [KEY_W-1:0]  src_key;
  logic [BAL_W-1:0]  amt_ext;
  logic [BAL_W:0]    dst_sum;
  logic              id_bad;
  logic              amt_bad;
  logic              key_bad;
  logic              ovf;
  logic              init_ok;

  always_comb begin
    src_bal = '0;
    dst_bal = '0;
    src_key = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (src_q == ID_W'(i)) begin
        src_bal = bal_q[i];
        src_key = key_table[i*KEY_W +: KEY_W];
      end
      if (dst_q == ID_W'(i)) begin
        dst_bal = bal_q[i];
      end
    end
  end

  assign amt_ext = BAL_W'(amt_q);
  assign id_bad  = ({1'b0, src_q} >= NP) ||
                   ({1'b0, dst_q} >= NP) ||
                   (src_q == dst_q);
  assign amt_bad = (amt_q == '0) || (amt_ext > src_bal);
  assign key_bad = (key_q != src_key);
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_ext};
  assign ovf     = dst_sum > {1'b0, {BAL_W{1'b1}}};
  assign init_ok = {1'b0, init_id} < NP;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    amt_d    = amt_q;
    key_d    = key_q;
    res_d    = res_q;
    done_d   = 1'b0;
    status_d = status_q;
    bal_d    = bal_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_id;
          dst_d   = dst_id;
          amt_d   = amount;
          key_d   = input_key;
          state_d = S_CHK_AMT;
        end else if (init_en && init_ok) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (init_id == ID_W'(i)) bal_d[i] = init_value;
          end
        end
      end
      S_CHK_AMT: begin
        if (id_bad) begin
          res_d   = ST_ERR_ID;
          state_d = S_RESP;
        end else if (amt_bad) begin
          res_d   = ST_ERR_AMT;
          state_d = S_RESP;
        end else begin
          state_d = S_CHK_KEY;
        end
      end
      S_CHK_KEY: begin
        if (key_bad) begin
          res_d   = ST_ERR_KEY;
          state_d = S_RESP;
        end else if (ovf) begin
          res_d   = ST_ERR_OVF;
          state_d = S_RESP;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // ids already validated distinct and in range
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (src_q == ID_W'(i)) begin
            bal_d[i] = bal_q[i] - amt_ext;
          end else if (dst_q == ID_W'(i)) begin
            bal_d[i] = bal_q[i] + amt_ext;
          end
        end
        res_d   = ST_OK;
        state_d = S_RESP;
      end
      S_RESP: begin
        done_d   = 1'b1;
        status_d = res_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      amt_q    <= '0;
      key_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      status_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) bal_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      amt_q    <= amt_d;
      key_q    <= key_d;
      res_q    <= res_d;
      done_q   <= done_d;
      status_q <= status_d;
      bal_q    <= bal_d;
    end
  end

  always_comb begin
    rd_balance = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (rd_id == ID_W'(i)) rd_balance = bal_q[i];
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign status = status_q;

`ifdef TXN_ENGINE_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // counters move on the same edge that raises done
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == S_RESP) begin
      if (res_q == ST_OK) begin
        if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
      end else begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ok_count  = ok_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_txn_engine.sv
// tb_txn_engine: directed checks of txn_engine (2-, 4- and 3-player builds).
// The 4- and 3-player instances share one stimulus bus.
module tb_txn_engine;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  amount = '0;
  logic [7:0]  input_key = '0;
  logic [10:0] init_value = '0;

  logic        start_a = 0, init_en_a = 0;
  logic        src_a = 0, dst_a = 0, init_id_a = 0, rd_a = 0;
  logic [15:0] key_table_a = {8'h5A, 8'hC3};
  logic [10:0] rd_bal_a;
  logic        busy_a, done_a;
  logic [2:0]  status_a;

  logic        start_bc = 0, init_en_bc = 0;
  logic [1:0]  src_bc = 0, dst_bc = 0, init_id_bc = 0, rd_bc = 0;
  logic [31:0] key_table_b = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [10:0] rd_bal_b, rd_bal_c;
  logic        busy_b, done_b, busy_c, done_c;
  logic [2:0]  status_b, status_c;

`ifdef TXN_ENGINE_STATS_EN
  logic [15:0] ok_a, err_a, ok_b, err_b, ok_c, err_c;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ea, eb, ec;
  logic [2:0] sa, sb, sc;

  always #5 clock = ~clock;

  txn_engine u_a (
    .clock(clock), .resetn(resetn), .start(start_a),
    .src_id(src_a), .dst_id(dst_a), .amount(amount),
    .input_key(input_key), .key_table(key_table_a),
    .init_en(init_en_a), .init_id(init_id_a),
    .init_value(init_value), .rd_id(rd_a),
    .rd_balance(rd_bal_a), .busy(busy_a),
    .done(done_a), .status(status_a)
`ifdef TXN_ENGINE_STATS_EN
    , .ok_count(ok_a), .err_count(err_a)
`endif
  );

  txn_engine #(.NUM_PLAYERS(4), .ID_W(2)) u_b (
    .clock(clock), .resetn(resetn), .start(start_bc),
    .src_id(src_bc), .dst_id(dst_bc), .amount(amount),
    .input_key(input_key), .key_table(key_table_b),
    .init_en(init_en_bc), .init_id(init_id_bc),
    .init_value(init_value), .rd_id(rd_bc),
    .rd_balance(rd_bal_b), .busy(busy_b),
    .done(done_b), .status(status_b)
`ifdef TXN_ENGINE_STATS_EN
    , .ok_count(ok_b), .err_count(err_b)
`endif
  );

  txn_engine #(.NUM_PLAYERS(3), .ID_W(2)) u_c (
    .clock(clock), .resetn(resetn), .start(start_bc),
    .src_id(src_bc), .dst_id(dst_bc), .amount(amount),
    .input_key(input_key), .key_table(key_table_b[23:0]),
    .init_en(init_en_bc), .init_id(init_id_bc),
    .init_value(init_value), .rd_id(rd_bc),
    .rd_balance(rd_bal_c), .busy(busy_c),
    .done(done_c), .status(status_c)
`ifdef TXN_ENGINE_STATS_EN
    , .ok_count(ok_c), .err_count(err_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init(input int grp, input logic [1:0] id,
                      input logic [10:0] v);
    init_value = v;
    if (grp == 0) begin
      init_en_a = 1; init_id_a = id[0];
    end else begin
      init_en_bc = 1; init_id_bc = id;
    end
    tick();
    init_en_a = 0;
    init_en_bc = 0;
  endtask

  task automatic rdchk(input int grp, input logic [1:0] id,
                       input logic [31:0] exp, input string tag);
    if (grp == 0) rd_a = id[0];
    else rd_bc = id;
    #1;
    case (grp)
      0: chk(tag, rd_bal_a, exp);
      1: chk(tag, rd_bal_b, exp);
      default: chk(tag, rd_bal_c, exp);
    endcase
  endtask

  // start on edge 0, scramble operands, then log the edge done is seen
  task automatic run(input int grp, input logic [1:0] s,
                     input logic [1:0] d, input logic [7:0] amt,
                     input logic [7:0] key);
    if (grp == 0) begin
      start_a = 1; src_a = s[0]; dst_a = d[0];
    end else begin
      start_bc = 1; src_bc = s; dst_bc = d;
    end
    amount = amt;
    input_key = key;
    tick();
    start_a = 0;
    start_bc = 0;
    src_a = ~src_a; dst_a = ~dst_a;
    src_bc = ~src_bc; dst_bc = ~dst_bc;
    amount = ~amount;
    input_key = ~input_key;
    ea = 99; eb = 99; ec = 99;
    sa = 7; sb = 7; sc = 7;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (done_a === 1'b1 && ea == 99) begin ea = e; sa = status_a; end
      if (done_b === 1'b1 && eb == 99) begin eb = e; sb = status_b; end
      if (done_c === 1'b1 && ec == 99) begin ec = e; sc = status_c; end
    end
  endtask

  initial begin
    #2;
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst status", status_a, 0);
    rdchk(0, 0, 0, "rst bal0");
    @(negedge clock);
    resetn = 1;
    tick();

    init(0, 0, 100);
    init(0, 1, 20);
    rdchk(0, 0, 100, "init bal0");
    rdchk(0, 1, 20, "init bal1");
    tick();

    run(0, 0, 1, 30, 8'hC3);
    chk("ok edge", ea, 4);
    chk("ok status", sa, 0);
    chk("ok status held", status_a, 0);
    rdchk(0, 0, 70, "ok bal0");
    rdchk(0, 1, 50, "ok bal1");
    tick();

    run(0, 0, 1, 101, 8'hC3);
    chk("amt edge", ea, 2);
    chk("amt status", sa, 2);
    chk("amt status held", status_a, 2);
    rdchk(0, 0, 70, "amt bal0");
    rdchk(0, 1, 50, "amt bal1");
    tick();

    run(0, 0, 1, 0, 8'hC3);
    chk("zero amt status", sa, 2);

    run(0, 1, 1, 5, 8'h5A);
    chk("id edge", ea, 2);
    chk("id status", sa, 1);

    run(0, 0, 1, 30, 8'h00);
    chk("key edge", ea, 3);
    chk("key status", sa, 3);
    rdchk(0, 0, 70, "key bal0");
    rdchk(0, 1, 50, "key bal1");
    tick();

    init(0, 1, 2040);
    run(0, 0, 1, 10, 8'hC3);
    chk("ovf edge", ea, 3);
    chk("ovf status", sa, 4);
    rdchk(0, 0, 70, "ovf bal0");
    rdchk(0, 1, 2040, "ovf bal1");
    tick();

    run(0, 0, 1, 7, 8'hC3);
    chk("full status", sa, 0);
    rdchk(0, 0, 63, "full bal0");
    rdchk(0, 1, 2047, "full bal1");
    tick();

    // second start at edge 1 and init at edge 2 must be ignored
    rd_a = 0;
    src_a = 1; dst_a = 0; amount = 47; input_key = 8'h5A;
    start_a = 1;
    tick();
    src_a = 0; dst_a = 1; amount = 1; input_key = 8'hC3;
    tick();
    start_a = 0;
    init_en_a = 1; init_id_a = 0; init_value = 999;
    tick();
    init_en_a = 0;
    chk("pre-commit rd", rd_bal_a, 63);
    tick();
    chk("post-commit rd", rd_bal_a, 110);
    chk("resp busy", busy_a, 1);
    tick();
    chk("ign done", done_a, 1);
    chk("ign status", status_a, 0);
    tick();
    chk("ign done low", done_a, 0);
    chk("ign idle", busy_a, 0);
    rdchk(0, 1, 2000, "ign bal1");
    tick();

    run(0, 0, 1, 5, 8'h00);
    chk("key2 status", sa, 3);
`ifdef TXN_ENGINE_STATS_EN
    chk("a ok count", ok_a, 3);
    chk("a err count", err_a, 6);
`endif

    // reset while in COMMIT
    src_a = 0; dst_a = 1; amount = 10; input_key = 8'hC3;
    start_a = 1;
    tick();
    start_a = 0;
    tick();
    tick();
    resetn = 0;
    #1;
    chk("mid rst busy", busy_a, 0);
    chk("mid rst done", done_a, 0);
    chk("mid rst status", status_a, 0);
    rdchk(0, 0, 0, "mid rst bal0");
    rdchk(0, 1, 0, "mid rst bal1");
`ifdef TXN_ENGINE_STATS_EN
    chk("rst ok count", ok_a, 0);
    chk("rst err count", err_a, 0);
`endif
    @(negedge clock);
    resetn = 1;
    tick();

    init(1, 0, 50);
    run(1, 0, 1, 10, 8'h11);
    chk("b 0-1 edge", eb, 4);
    chk("c 0-1 status", sc, 0);
    run(1, 1, 2, 10, 8'h22);
    chk("b 1-2 status", sb, 0);
    run(1, 2, 3, 10, 8'h33);
    chk("b 2-3 status", sb, 0);
    chk("c 2-3 edge", ec, 2);
    chk("c 2-3 status", sc, 1);
    run(1, 3, 0, 5, 8'h44);
    chk("b 3-0 status", sb, 0);
    chk("c src3 status", sc, 1);

    rdchk(1, 0, 45, "b bal0");
    rdchk(1, 1, 0, "b bal1");
    rdchk(1, 2, 0, "b bal2");
    tick();
    rdchk(1, 3, 5, "b bal3");
    rdchk(2, 0, 40, "c bal0");
    rdchk(2, 2, 10, "c bal2");
    tick();
`ifdef TXN_ENGINE_STATS_EN
    chk("b ok count", ok_b, 4);
    chk("b err count", err_b, 0);
    chk("c ok count", ok_c, 2);
    chk("c err count", err_c, 2);
`endif

    init(1, 3, 77);
    rdchk(1, 3, 77, "b init3");
    rdchk(2, 3, 0, "c init3 dropped");
    rdchk(2, 0, 40, "c bal0 kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
